// File: rtl/dispatch_sequencer.sv
// dispatch_sequencer
//   Buffers fetched instruction words in a small FIFO and presents them one
//   beat at a time to decode. LDP/STP words are issued as two micro-op beats.
//   An HLT freezes the block until reset. A flush discards all buffered work.
//
// Ports
//   in_clk            clock, rising edge
//   in_rst            synchronous active-high reset
//   in_fetch_insnbits instruction word from fetch
//   in_fetch_done     fetch word valid this cycle
//   in_stall          decode cannot accept a beat this cycle
//   in_flush          squash all buffered work
//   out_fetch_stall   fetch word is not accepted this cycle
//   out_insnbits      head instruction word presented to decode
//   out_done          beat valid to decode
//   out_uop_idx       0 = first/only micro-op, 1 = second half of a pair
//   out_cracked       head word is LDP/STP (two beats)
//   out_halted        an HLT has been dispatched
//   out_uop_count     micro-ops dispatched since reset (wraps)
module dispatch_sequencer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic [31:0]      in_fetch_insnbits,
  input  logic             in_fetch_done,
  input  logic             in_stall,
  input  logic             in_flush,
  output logic             out_fetch_stall,
  output logic [31:0]      out_insnbits,
  output logic             out_done,
  output logic             out_uop_idx,
  output logic             out_cracked,
  output logic             out_halted,
  output logic [CNT_W-1:0] out_uop_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [0:0] S_FIRST  = 1'b0;
  localparam logic [0:0] S_SECOND = 1'b1;

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic [0:0]       state_reg;
  logic             halted_reg;
  logic [CNT_W-1:0] count_reg;

  logic [31:0] entries [DEPTH];
  logic [31:0] head;
  logic        full;
  logic        push;
  logic        transfer;
  logic        pop;
  logic        head_cracked;
  logic        head_hlt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Each buffer entry is its own register so the head mux reads flops
  // directly; entries are cleared on reset so the presented word starts at 0.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] entry_reg;
      always_ff @(posedge in_clk) begin
        if (in_rst) begin
          entry_reg <= '0;
        end else if (push && wr_ptr_reg == PTR_W'(gi)) begin
          entry_reg <= in_fetch_insnbits;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign head = entries[rd_ptr_reg];

  // LDP: 1010_1000_11xx..., STP: 1010_1001_00xx...
  assign head_cracked = (head[31:22] == 10'b1010100011) ||
                        (head[31:22] == 10'b1010100100);
  // HLT: 1101_0100_010x_..._xxx0_0000
  assign head_hlt     = (head[31:21] == 11'b11010100010) && (head[4:0] == 5'b0);

  assign full     = (occ_reg == OCC_W'(DEPTH));
  assign push     = in_fetch_done && !out_fetch_stall && !in_flush;
  assign transfer = out_done && !in_stall && !in_flush;
  // The first half of a cracked word leaves the head in place for the second.
  assign pop      = transfer && ((state_reg == S_SECOND) || !head_cracked);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
      state_reg  <= S_FIRST;
      halted_reg <= 1'b0;
      count_reg  <= '0;
    end else if (in_flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
      state_reg  <= S_FIRST;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (push && !pop) begin
        occ_reg <= occ_reg + OCC_W'(1);
      end else if (pop && !push) begin
        occ_reg <= occ_reg - OCC_W'(1);
      end
      if (transfer) begin
        count_reg <= count_reg + CNT_W'(1);
        if (state_reg == S_FIRST && head_cracked) begin
          state_reg <= S_SECOND;
        end else begin
          state_reg <= S_FIRST;
        end
        if (head_hlt) begin
          halted_reg <= 1'b1;
        end
      end
    end
  end

  // All outputs come from registered state only.
  assign out_fetch_stall = full || halted_reg;
  assign out_done        = (occ_reg != '0) && !halted_reg;
  assign out_insnbits    = head;
  assign out_uop_idx     = (state_reg == S_SECOND);
  assign out_cracked     = head_cracked;
  assign out_halted      = halted_reg;
  assign out_uop_count   = count_reg;

endmodule

// File: tb/tb_dispatch_sequencer.sv
// Directed testbench for dispatch_sequencer. Inputs change 1 time unit after
// a rising edge; outputs are sampled at that same point, after the edge that
// consumed the previous input settings.
module tb_dispatch_sequencer;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic [31:0] in_fetch_insnbits = '0;
  logic        in_fetch_done = 1'b0;
  logic        in_stall = 1'b0;
  logic        in_flush = 1'b0;
  logic        out_fetch_stall;
  logic [31:0] out_insnbits;
  logic        out_done;
  logic        out_uop_idx;
  logic        out_cracked;
  logic        out_halted;
  logic [15:0] out_uop_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_count = 0;

  localparam logic [31:0] ADD = 32'h91000421;
  localparam logic [31:0] LDP = 32'hA8C107E0;
  localparam logic [31:0] STP = 32'hA9007BFD;
  localparam logic [31:0] HLT = 32'hD4400000;
  localparam logic [31:0] W1  = 32'h8B020020;
  localparam logic [31:0] W2  = 32'hD2800001;
  localparam logic [31:0] W3  = 32'hAA0103E2;

  dispatch_sequencer #(.DEPTH(2), .CNT_W(16)) dut (
    .in_clk            (in_clk),
    .in_rst            (in_rst),
    .in_fetch_insnbits (in_fetch_insnbits),
    .in_fetch_done     (in_fetch_done),
    .in_stall          (in_stall),
    .in_flush          (in_flush),
    .out_fetch_stall   (out_fetch_stall),
    .out_insnbits      (out_insnbits),
    .out_done          (out_done),
    .out_uop_idx       (out_uop_idx),
    .out_cracked       (out_cracked),
    .out_halted        (out_halted),
    .out_uop_count     (out_uop_count)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] w);
    in_fetch_done     = 1'b1;
    in_fetch_insnbits = w;
  endtask

  task automatic idle_fetch();
    in_fetch_done = 1'b0;
  endtask

  initial begin
    int n;

    // Reset state
    step();
    check("rst_done", 32'(out_done), 0);
    check("rst_fstall", 32'(out_fetch_stall), 0);
    check("rst_idx", 32'(out_uop_idx), 0);
    check("rst_halted", 32'(out_halted), 0);
    check("rst_count", 32'(out_uop_count), 0);
    check("rst_insn", out_insnbits, 0);
    check("rst_cracked", 32'(out_cracked), 0);
    in_rst = 1'b0;

    // Pass-through ADD
    offer(ADD); step(); idle_fetch();
    check("pt_done", 32'(out_done), 1);
    check("pt_insn", out_insnbits, ADD);
    check("pt_idx", 32'(out_uop_idx), 0);
    check("pt_cracked", 32'(out_cracked), 0);
    step(); exp_count++;
    check("pt_done_after", 32'(out_done), 0);
    check("pt_count", 32'(out_uop_count), 32'(exp_count));

    // Crack LDP into two beats
    offer(LDP); step(); idle_fetch();
    check("ldp_b0_done", 32'(out_done), 1);
    check("ldp_b0_idx", 32'(out_uop_idx), 0);
    check("ldp_b0_cracked", 32'(out_cracked), 1);
    step(); exp_count++;
    check("ldp_b1_done", 32'(out_done), 1);
    check("ldp_b1_idx", 32'(out_uop_idx), 1);
    check("ldp_b1_cracked", 32'(out_cracked), 1);
    check("ldp_b1_insn", out_insnbits, LDP);
    step(); exp_count++;
    check("ldp_empty_done", 32'(out_done), 0);
    check("ldp_empty_fstall", 32'(out_fetch_stall), 0);
    check("ldp_count", 32'(out_uop_count), 32'(exp_count));

    // Backpressure: three words offered while decode stalls
    in_stall = 1'b1;
    offer(W1); step();
    check("bp_w1_insn", out_insnbits, W1);
    check("bp_w1_fstall", 32'(out_fetch_stall), 0);
    offer(W2); step();
    check("bp_full_fstall", 32'(out_fetch_stall), 1);
    check("bp_full_insn", out_insnbits, W1);
    offer(W3); step();
    check("bp_w3_rejected_fstall", 32'(out_fetch_stall), 1);
    check("bp_w3_rejected_insn", out_insnbits, W1);
    in_stall = 1'b0;
    step(); exp_count++;
    check("bp_w2_insn", out_insnbits, W2);
    check("bp_w2_fstall", 32'(out_fetch_stall), 0);
    step(); exp_count++; idle_fetch();
    check("bp_w3_done", 32'(out_done), 1);
    check("bp_w3_insn", out_insnbits, W3);
    step(); exp_count++;
    check("bp_drained_done", 32'(out_done), 0);
    check("bp_count", 32'(out_uop_count), 32'(exp_count));

    // Flush while an STP sits in its second half with decode stalled
    offer(STP); step(); idle_fetch();
    check("stp_b0_cracked", 32'(out_cracked), 1);
    step(); exp_count++;
    check("stp_b1_idx", 32'(out_uop_idx), 1);
    in_stall = 1'b1; in_flush = 1'b1; offer(W1);
    step();
    in_flush = 1'b0; idle_fetch(); in_stall = 1'b0;
    check("fl_done", 32'(out_done), 0);
    check("fl_fstall", 32'(out_fetch_stall), 0);
    check("fl_idx", 32'(out_uop_idx), 0);
    check("fl_count", 32'(out_uop_count), 32'(exp_count));
    step();
    check("fl_push_dropped", 32'(out_done), 0);

    // Reset in the middle of a crack
    offer(LDP); step(); idle_fetch();
    step();
    check("rc_idx_before", 32'(out_uop_idx), 1);
    in_rst = 1'b1; step(); in_rst = 1'b0; exp_count = 0;
    check("rc_idx", 32'(out_uop_idx), 0);
    check("rc_done", 32'(out_done), 0);
    check("rc_count", 32'(out_uop_count), 0);
    offer(ADD); step(); idle_fetch();
    check("rc_next_idx", 32'(out_uop_idx), 0);
    check("rc_next_insn", out_insnbits, ADD);
    check("rc_next_cracked", 32'(out_cracked), 0);
    step(); exp_count++;

    // Stream ADDs until the counter sits at 0xFFFF, then dispatch HLT
    n = 16'hFFFF - exp_count;
    offer(ADD);
    for (int i = 0; i < n; i++) step();
    idle_fetch();
    step();
    exp_count += n;
    check("wrap_pre_count", 32'(out_uop_count), 32'(exp_count));
    check("wrap_pre_done", 32'(out_done), 0);
    offer(HLT); step(); idle_fetch();
    check("hlt_insn", out_insnbits, HLT);
    check("hlt_done", 32'(out_done), 1);
    step();
    check("hlt_count_wrap", 32'(out_uop_count), 0);
    check("hlt_halted", 32'(out_halted), 1);
    check("hlt_done_after", 32'(out_done), 0);
    check("hlt_fstall", 32'(out_fetch_stall), 1);
    offer(ADD); step(); step();
    check("hlt_frozen_done", 32'(out_done), 0);
    check("hlt_frozen_count", 32'(out_uop_count), 0);
    in_flush = 1'b1; step(); in_flush = 1'b0;
    check("hlt_flush_keeps", 32'(out_halted), 1);
    check("hlt_flush_fstall", 32'(out_fetch_stall), 1);
    idle_fetch();
    in_rst = 1'b1; step(); in_rst = 1'b0;
    check("hlt_rst_halted", 32'(out_halted), 0);
    check("hlt_rst_fstall", 32'(out_fetch_stall), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
